// File: rtl/d_flip_flop.sv
`timescale 1ns/1ps
// D-type register with async active-low clear/preset and complementary outputs; preset gated by DFF_PRESET_EN.
// Latency: d appears on q after one rising clk edge; clear/preset act immediately. No backpressure.
// Without DFF_PRESET_EN the preset port is kept for drop-in compatibility but has no effect.
module d_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

`ifdef DFF_PRESET_EN
  // clear outranks preset when both are low
  always_ff @(posedge clk or negedge clear or negedge preset) begin
    if (!clear) begin
      q <= '0;
    end else if (!preset) begin
      q <= '1;
    end else begin
      q <= d;
    end
  end
`else
  logic unused_preset;
  assign unused_preset = preset;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end
`endif

  assign q_bar = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
`timescale 1ns/1ps
// Randomised bench for d_flip_flop (1-bit and 4-bit instances) against an event-level reference model.
module tb_d_flip_flop;

`ifdef DFF_PRESET_EN
  localparam bit PRESET_EN = 1'b1;
`else
  localparam bit PRESET_EN = 1'b0;
`endif

  logic       clk;
  logic       clear;
  logic       preset;
  logic       d1;
  logic [3:0] d4;
  logic       q1, qb1;
  logic [3:0] q4, qb4;

  logic       exp1;
  logic [3:0] exp4;
  int         checks;
  int         errors;

  d_flip_flop u_dut1 (
    .clk(clk), .clear(clear), .preset(preset), .d(d1), .q(q1), .q_bar(qb1)
  );

  d_flip_flop #(.WIDTH(4)) u_dut4 (
    .clk(clk), .clear(clear), .preset(preset), .d(d4), .q(q4), .q_bar(qb4)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Reference: a rising edge stores d only when no asynchronous control is active.
  always @(posedge clk) begin
    if (clear && (!PRESET_EN || preset)) begin
      exp1 = d1;
      exp4 = d4;
    end
  end

  // Asynchronous controls: asserting one forces the stored value, releasing changes nothing.
  task automatic drive_async(input logic c, input logic p);
    clear  = c;
    preset = p;
    if (!c) begin
      exp1 = 1'b0;
      exp4 = 4'h0;
    end else if (PRESET_EN && !p) begin
      exp1 = 1'b1;
      exp4 = 4'hf;
    end
  endtask

  task automatic test_reset();
    d1 = 1'b1;
    d4 = 4'hf;
    drive_async(1'b0, 1'b1);
    #20;
    checks++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      errors++; $display("FAIL reset_1b: q=%b q_bar=%b expected q=0 q_bar=1", q1, qb1);
    end
    checks++;
    if (q4 !== 4'h0 || qb4 !== 4'hf) begin
      errors++; $display("FAIL reset_4b: q=%b q_bar=%b expected q=0000 q_bar=1111", q4, qb4);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0 || q4 !== 4'h0) begin
      errors++; $display("FAIL reset_ignores_clk: q1=%b q4=%b expected 0/0000", q1, q4);
    end
    @(negedge clk);
    drive_async(1'b1, 1'b1);
  endtask

  task automatic test_follow();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d1 = 1'($urandom);
      d4 = 4'($urandom);
      #10;
      checks++;
      if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4 || qb4 !== ~exp4) begin
        errors++; $display("FAIL follow_hold[%0d]: q1=%b q4=%b expected %b/%b", i, q1, q4, exp1, exp4);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q1 !== d1 || qb1 !== ~d1 || q4 !== d4 || qb4 !== ~d4) begin
        errors++; $display("FAIL follow_capture[%0d]: q1=%b q4=%b expected %b/%b", i, q1, q4, d1, d4);
      end
    end
  endtask

  task automatic test_clear_async();
    @(negedge clk);
    d1 = 1'b1;
    d4 = 4'hf;
    @(posedge clk);
    #25;
    drive_async(1'b0, 1'b1);
    #1;
    checks++;
    if (q1 !== 1'b0 || qb1 !== 1'b1 || q4 !== 4'h0 || qb4 !== 4'hf) begin
      errors++; $display("FAIL clear_immediate: q1=%b qb1=%b q4=%b expected 0/1/0000", q1, qb1, q4);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0 || q4 !== 4'h0) begin
      errors++; $display("FAIL clear_blocks_clk: q1=%b q4=%b expected 0/0000", q1, q4);
    end
    @(negedge clk);
    drive_async(1'b1, 1'b1);
    #1;
    checks++;
    if (q1 !== 1'b0 || q4 !== 4'h0) begin
      errors++; $display("FAIL clear_release_holds: q1=%b q4=%b expected 0/0000", q1, q4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b1 || q4 !== 4'hf) begin
      errors++; $display("FAIL clear_release_capture: q1=%b q4=%b expected 1/1111", q1, q4);
    end
  endtask

  task automatic test_preset_async();
    @(negedge clk);
    d1 = 1'b0;
    d4 = 4'h0;
    @(posedge clk);
    #25;
    drive_async(1'b1, 1'b0);
    #1;
    checks++;
    if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4) begin
      errors++; $display("FAIL preset_immediate: q1=%b q4=%b expected %b/%b", q1, q4, exp1, exp4);
    end
    @(negedge clk);
    d1 = 1'b1;
    d4 = 4'($urandom);
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== exp1 || q4 !== exp4) begin
      errors++; $display("FAIL preset_held_edge: q1=%b q4=%b expected %b/%b", q1, q4, exp1, exp4);
    end
    @(negedge clk);
    d1 = 1'b0;
    d4 = 4'h0;
    drive_async(1'b1, 1'b1);
    #1;
    checks++;
    if (q1 !== exp1 || q4 !== exp4) begin
      errors++; $display("FAIL preset_release_holds: q1=%b q4=%b expected %b/%b", q1, q4, exp1, exp4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b0 || qb1 !== 1'b1 || q4 !== 4'h0) begin
      errors++; $display("FAIL preset_release_capture: q1=%b q4=%b expected 0/0000", q1, q4);
    end
  endtask

  task automatic test_async_cycle();
    logic c_seq [5];
    logic p_seq [5];
    c_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    p_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      drive_async(c_seq[s], p_seq[s]);
      #1;
      checks++;
      if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4 || qb4 !== ~exp4) begin
        errors++; $display("FAIL cycle_entry[%0d]: q1=%b q4=%b expected %b/%b", s, q1, q4, exp1, exp4);
      end
      for (int k = 0; k < 2; k++) begin
        d1 = 1'($urandom);
        d4 = 4'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4 || qb4 !== ~exp4) begin
          errors++; $display("FAIL cycle_step[%0d.%0d]: q1=%b q4=%b expected %b/%b", s, k, q1, q4, exp1, exp4);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_wide();
    d4 = 4'b1010;
    @(posedge clk);
    #1;
    checks++;
    if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
      errors++; $display("FAIL wide_capture: q=%b q_bar=%b expected 1010/0101", q4, qb4);
    end
    #20;
    drive_async(1'b1, 1'b0);
    #1;
    checks++;
    if (q4 !== (PRESET_EN ? 4'b1111 : 4'b1010) || qb4 !== ~q4) begin
      errors++; $display("FAIL wide_preset: q=%b q_bar=%b expected %b", q4, qb4, PRESET_EN ? 4'b1111 : 4'b1010);
    end
    @(negedge clk);
    drive_async(1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d1 = 1'($urandom);
      d4 = 4'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4 || qb4 !== ~exp4) begin
        errors++; $display("FAIL b2b[%0d]: q1=%b q4=%b expected %b/%b", i, q1, q4, exp1, exp4);
      end
      if ($urandom_range(0, 5) == 0) begin
        #15;
        if ($urandom_range(0, 1) == 0) drive_async(1'b0, 1'b1);
        else drive_async(1'b1, 1'b0);
        #1;
        checks++;
        if (q1 !== exp1 || qb1 !== ~exp1 || q4 !== exp4) begin
          errors++; $display("FAIL b2b_pulse[%0d]: q1=%b q4=%b expected %b/%b", i, q1, q4, exp1, exp4);
        end
        #10;
        drive_async(1'b1, 1'b1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp1   = 1'b0;
    exp4   = 4'h0;
    preset = 1'b1;
    test_reset();
    test_follow();
    test_clear_async();
    test_preset_async();
    test_async_cycle();
    test_wide();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
